// File: rtl/note_fall_engine.sv
// Falling-note frame engine: shifts a ROWS x COLS note frame down one row per tick, judges key presses, keeps score.
// Latency: tick_in rise -> note_ready strobe 3 clk later, frame shifts on the following edge; hit/miss pulses 1 clk after the event.
// Backpressure: note_ready is a 1-cycle strobe on each active step; the chart source holds note_valid/note_data until accepted.
// Optional feature: define NOTE_FALL_COMBO_EN to enable the combo counter and double points above COMBO_BONUS.
module note_fall_engine #(
  parameter int COLS        = 8,
  parameter int ROWS        = 8,
  parameter int SCORE_MAX   = 9999,
  parameter int COMBO_BONUS = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick_in,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    chart_end,
  input  logic                    note_valid,
  input  logic [COLS-1:0]         note_data,
  output logic                    note_ready,
  input  logic [COLS-1:0]         key,
  input  logic [$clog2(ROWS)-1:0] row_sel,
  output logic [COLS-1:0]         row_data,
  output logic                    hit_pulse,
  output logic                    miss_pulse,
  output logic [13:0]             score,
  output logic [9:0]              miss_cnt,
  output logic [7:0]              combo,
  output logic                    done
);

  localparam int CW = $clog2(COLS + 1);
  localparam logic [14:0] SMAX = 15'(SCORE_MAX);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t          state, state_nx;
  logic [COLS-1:0] frame [ROWS];
  logic            tick_s1, tick_s2, tick_q, step;
  logic [COLS-1:0] key_q, kedge, hits, misses;
  logic            active, running, frame_empty, shift, combo_ok;
  logic [CW-1:0]   hit_cnt, miss_add;
  logic [14:0]     score_sum;
  logic [10:0]     miss_sum;
  logic [CW:0]     pts;

  function automatic logic [CW-1:0] popcnt(input logic [COLS-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < COLS; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  // tick synchroniser, rising-edge detect registered into a 1-cycle step, key history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_s1 <= 1'b0;
      tick_s2 <= 1'b0;
      tick_q  <= 1'b0;
      step    <= 1'b0;
      key_q   <= '0;
    end else begin
      tick_s1 <= tick_in;
      tick_s2 <= tick_s1;
      tick_q  <= tick_s2;
      step    <= tick_s2 & ~tick_q;
      key_q   <= key;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state: start always (re)enters RUN and beats chart_end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (start) state_nx = RUN;
               else if (chart_end) state_nx = DRAIN;
      DRAIN:   if (start) state_nx = RUN;
               else if (frame_empty) state_nx = FIN;
      FIN:     if (start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  // state-decoded controls
  always_comb begin
    active  = ((state == RUN) || (state == DRAIN)) && !pause;
    running = (state == RUN) && !pause;
    done    = (state == FIN);
  end

  // judging, shifting and counter arithmetic against the pre-shift judge row
  always_comb begin
    frame_empty = 1'b1;
    for (int r = 0; r < ROWS; r++) if (frame[r] != '0) frame_empty = 1'b0;
    kedge      = key & ~key_q;
    note_ready = step & running;
    shift      = step & active;
    hits       = active ? (kedge & frame[ROWS-1]) : '0;
    misses     = shift ? (frame[ROWS-1] & ~hits) : '0;
    hit_cnt    = popcnt(hits);
    miss_add   = popcnt(misses);
    pts        = combo_ok ? {hit_cnt, 1'b0} : {1'b0, hit_cnt};
    score_sum  = {1'b0, score} + 15'(pts);
    miss_sum   = {1'b0, miss_cnt} + 11'(miss_add);
    row_data   = frame[row_sel];
  end

  // frame: start clears, step shifts in the accepted chart row (or zeros), hits clear judge-row bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) frame[r] <= '0;
    end else if (start) begin
      for (int r = 0; r < ROWS; r++) frame[r] <= '0;
    end else if (shift) begin
      for (int r = ROWS - 1; r > 0; r--) frame[r] <= frame[r-1];
      frame[0] <= (note_valid && note_ready) ? note_data : '0;
    end else if (hits != '0) begin
      frame[ROWS-1] <= frame[ROWS-1] & ~hits;
    end
  end

  // saturating score / miss counters and registered event pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score      <= '0;
      miss_cnt   <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else if (start) begin
      score      <= '0;
      miss_cnt   <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      score      <= (score_sum > SMAX) ? SMAX[13:0] : score_sum[13:0];
      miss_cnt   <= miss_sum[10] ? 10'h3FF : miss_sum[9:0];
      hit_pulse  <= (hits != '0);
      miss_pulse <= (misses != '0);
    end
  end

`ifdef NOTE_FALL_COMBO_EN
  logic [8:0] combo_sum;

  // combo restarts from this cycle's hits whenever a note is lost
  always_comb begin
    combo_sum = ((misses != '0) ? 9'd0 : {1'b0, combo}) + 9'(hit_cnt);
    combo_ok  = (combo >= 8'(COMBO_BONUS));
  end

  // saturating combo register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     combo <= '0;
    else if (start) combo <= '0;
    else            combo <= combo_sum[8] ? 8'hFF : combo_sum[7:0];
  end
`else
  // no combo tracking: flat one point per hit
  always_comb begin
    combo    = 8'd0;
    combo_ok = (combo >= 8'(COMBO_BONUS));
  end
`endif

endmodule

// File: tb/tb_note_fall_engine.sv
// Directed bench for note_fall_engine: frame fill, hit/miss judging, pause, drain, combo scoring, saturation, async reset.
// Latency: inputs driven on the falling clock edge, outputs sampled on the falling edge.
// Backpressure: chart source holds note_valid/note_data across ticks until the engine strobes note_ready.
module tb_note_fall_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_in = 1'b0, start = 1'b0, pause = 1'b0, chart_end = 1'b0, note_valid = 1'b0;
  logic [7:0]  note_data = '0, key = '0;
  logic [2:0]  row_sel = 3'd7;
  logic        note_ready, hit_pulse, miss_pulse, done;
  logic [7:0]  row_data, combo;
  logic [13:0] score;
  logic [9:0]  miss_cnt;

  int compared = 0, mismatched = 0;
  int rdy_cycles = 0, hit_cycles = 0, miss_cycles = 0;
  int exp_score, exp_combo;

  always #5 clk = ~clk;

  note_fall_engine dut (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .start(start), .pause(pause),
    .chart_end(chart_end), .note_valid(note_valid), .note_data(note_data),
    .note_ready(note_ready), .key(key), .row_sel(row_sel), .row_data(row_data),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .score(score),
    .miss_cnt(miss_cnt), .combo(combo), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one fall tick (8 clk); optionally press k exactly in the step cycle
  task automatic do_tick(input logic [7:0] k);
    tick_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 3) tick_in = 1'b0;
      if (note_ready) rdy_cycles++;
      if (hit_pulse)  hit_cycles++;
      if (miss_pulse) miss_cycles++;
      key = note_ready ? k : 8'h00;
    end
    key = 8'h00;
  endtask

  task automatic press(input logic [7:0] k);
    key = k;
    @(negedge clk);
    key = 8'h00;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic peek_row(input logic [2:0] r, input string tag, input logic [7:0] exp);
    row_sel = r;
    #1;
    chk(tag, row_data, exp);
    row_sel = 3'd7;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_score", score, 0);
    chk("rst_miss", miss_cnt, 0);
    chk("rst_combo", combo, 0);
    chk("rst_done", done, 0);
    chk("rst_row", row_data, 0);
    chk("rst_ready", note_ready, 0);
    chk("rst_hitp", hit_pulse, 0);
    chk("rst_missp", miss_pulse, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: fill frame with lane-0 notes, one ready strobe per tick
    pulse_start();
    note_valid = 1'b1; note_data = 8'h01;
    rdy_cycles = 0;
    repeat (8) do_tick(8'h00);
    chk("t1_ready_strobes", rdy_cycles, 8);
    peek_row(3'd7, "t1_row7", 8'h01);
    peek_row(3'd0, "t1_row0", 8'h01);
    chk("t1_miss", miss_cnt, 0);

    // 2: key[0] rises between ticks -> hit
    note_valid = 1'b0;
    key = 8'h01;
    @(negedge clk);
    key = 8'h00;
    chk("t2_hitp_on", hit_pulse, 1);
    chk("t2_score", score, 1);
    chk("t2_row7_clear", row_data, 8'h00);
    @(negedge clk);
    chk("t2_hitp_off", hit_pulse, 0);
    chk("t2_miss", miss_cnt, 0);

    // 3: lanes 0 and 3 fall off the bottom unpressed
    pulse_start();
    chk("t3_score_clr", score, 0);
    note_valid = 1'b1; note_data = 8'h09;
    do_tick(8'h00);
    note_valid = 1'b0;
    repeat (7) do_tick(8'h00);
    peek_row(3'd7, "t3_row7", 8'h09);
    miss_cycles = 0;
    do_tick(8'h00);
    chk("t3_missp_cycles", miss_cycles, 1);
    chk("t3_miss_cnt", miss_cnt, 2);
    chk("t3_row7_after", row_data, 8'h00);

    // 4: key edge in the same cycle as the step -> hit wins, row shifts
    pulse_start();
    note_valid = 1'b1; note_data = 8'h01;
    do_tick(8'h00);
    note_data = 8'h02;
    do_tick(8'h00);
    note_valid = 1'b0;
    repeat (6) do_tick(8'h00);
    peek_row(3'd7, "t4_row7_pre", 8'h01);
    hit_cycles = 0;
    do_tick(8'h01);
    chk("t4_score", score, 1);
    chk("t4_miss", miss_cnt, 0);
    chk("t4_hitp_cycles", hit_cycles, 1);
    peek_row(3'd7, "t4_row7_shifted", 8'h02);

    // 5: pause freezes the frame; chart_end then drain to done
    pause = 1'b1;
    rdy_cycles = 0;
    repeat (4) do_tick(8'h00);
    chk("t5_pause_ready", rdy_cycles, 0);
    peek_row(3'd7, "t5_pause_row7", 8'h02);
    chk("t5_pause_miss", miss_cnt, 0);
    chk("t5_not_done", done, 0);
    pause = 1'b0;
    chart_end = 1'b1;
    @(negedge clk);
    chart_end = 1'b0;
    rdy_cycles = 0;
    repeat (8) do_tick(8'h00);
    chk("t5_drain_ready", rdy_cycles, 0);
    chk("t5_done", done, 1);
    chk("t5_drain_miss", miss_cnt, 1);

    // 6: twelve consecutive hits, then a miss
    pulse_start();
    chk("t6_restart_done", done, 0);
    note_valid = 1'b1; note_data = 8'h01;
    repeat (8) do_tick(8'h00);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) do_tick(8'h00);
      press(8'h01);
    end
`ifdef NOTE_FALL_COMBO_EN
    exp_score = 14; exp_combo = 12;
`else
    exp_score = 12; exp_combo = 0;
`endif
    chk("t6_score", score, exp_score);
    chk("t6_combo", combo, exp_combo);
    do_tick(8'h00);
    chk("t6_no_miss_yet", miss_cnt, 0);
    do_tick(8'h00);
    chk("t6_miss", miss_cnt, 1);
    chk("t6_combo_reset", combo, 0);

    // 7: drive score into saturation with full-row hits
    pulse_start();
    note_valid = 1'b1; note_data = 8'hFF;
    repeat (8) do_tick(8'h00);
    for (int i = 0; i < 1300; i++) begin
      press(8'hFF);
      do_tick(8'h00);
    end
    chk("t7_score_sat", score, 9999);
    chk("t7_miss", miss_cnt, 0);
    peek_row(3'd7, "t7_row7_full", 8'hFF);

    // asynchronous reset in the middle of a hit
    key = 8'hFF;
    @(posedge clk);
    #1;
    key = 8'h00;
    chk("t7_hitp_pre", hit_pulse, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_arst_score", score, 0);
    chk("t7_arst_hitp", hit_pulse, 0);
    chk("t7_arst_row", row_data, 0);
    chk("t7_arst_done", done, 0);
    chk("t7_arst_combo", combo, 0);
    chk("t7_arst_miss", miss_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
